// File: rtl/rw_stage_if.sv
// rw_stage_if: MA-to-RW handshake/payload bus plus the register-bank write port,
// forwarding copies and status. The master modport is the MA stage and
// register-bank side. The slave modport is the RW stage.
interface rw_stage_if #(
  parameter int unsigned CNT_W = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [31:0]      instruction;
  logic [31:0]      pc;
  logic [31:0]      alu_result;
  logic [31:0]      ld_result;
  logic             is_ld;
  logic             is_call;
  logic             is_wb_in;
  logic             is_halt;
  logic             is_wb;
  logic [3:0]       wr_adr;
  logic [31:0]      wr_data;
  logic             fwd_valid;
  logic [3:0]       fwd_adr;
  logic [31:0]      fwd_data;
  logic             halted;
  logic [CNT_W-1:0] retired_cnt;

  modport master (
    output in_valid, instruction, pc, alu_result, ld_result,
    output is_ld, is_call, is_wb_in, is_halt,
    input  in_ready, is_wb, wr_adr, wr_data, fwd_valid, fwd_adr, fwd_data,
    input  halted, retired_cnt
  );

  modport slave (
    input  in_valid, instruction, pc, alu_result, ld_result,
    input  is_ld, is_call, is_wb_in, is_halt,
    output in_ready, is_wb, wr_adr, wr_data, fwd_valid, fwd_adr, fwd_data,
    output halted, retired_cnt
  );
endinterface

// File: rtl/rw_stage.sv
// rw_stage: SimpleRisc register-writeback stage. It latches one retiring instruction
// per cycle and drives the register-bank write port. It also exposes that write for
// forwarding and freezes the pipeline once a halt instruction retires.
// Optional feature: define RW_RETIRE_CNT_EN to build the retire counter. Without it,
// retired_cnt is tied to 0.
module rw_stage #(
  parameter logic [3:0]  RA_ADR = 4'hF,
  parameter int unsigned CNT_W  = 32
) (
  input  logic        clk,
  input  logic        reset,
  rw_stage_if.slave   bus
);

  typedef enum logic [1:0] {StRun, StDrain, StHalted} state_e;

  state_e      state_q, state_d;
  logic        accept;
  logic        is_wb_q;
  logic [3:0]  wr_adr_q;
  logic [31:0] wr_data_q;
  logic [31:0] pc_plus4;
  logic        unused_instr_bits;

  // in_ready depends only on state, so there is no valid-to-ready combinational path.
  assign bus.in_ready = (state_q == StRun);
  assign accept       = bus.in_valid && bus.in_ready;
  assign pc_plus4     = bus.pc + 32'd4;
  assign unused_instr_bits = ^{bus.instruction[31:26], bus.instruction[21:0]};

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= StRun;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state: a retiring halt drains for one cycle, then the stage freezes until reset.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StRun:    if (accept && bus.is_halt) state_d = StDrain;
      StDrain:  state_d = StHalted;
      StHalted: state_d = StHalted;
      default:  state_d = StRun;
    endcase
  end

  // Write-port registers. Address and data hold between accepts; the enable drops.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      is_wb_q   <= 1'b0;
      wr_adr_q  <= 4'h0;
      wr_data_q <= 32'h0;
    end else if (accept) begin
      is_wb_q   <= bus.is_wb_in;
      wr_adr_q  <= bus.is_call ? RA_ADR : bus.instruction[25:22];
      wr_data_q <= bus.is_call ? pc_plus4 : (bus.is_ld ? bus.ld_result : bus.alu_result);
    end else begin
      is_wb_q   <= 1'b0;
    end
  end

  assign bus.is_wb     = is_wb_q;
  assign bus.wr_adr    = wr_adr_q;
  assign bus.wr_data   = wr_data_q;
  assign bus.fwd_valid = is_wb_q;
  assign bus.fwd_adr   = wr_adr_q;
  assign bus.fwd_data  = wr_data_q;
  assign bus.halted    = (state_q == StHalted);

`ifdef RW_RETIRE_CNT_EN
  logic [CNT_W-1:0] cnt_q;

  // Retire counter: counts every accept and wraps naturally.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
    end else if (accept) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign bus.retired_cnt = cnt_q;
`else
  assign bus.retired_cnt = {CNT_W{1'b0}};
`endif

endmodule

// File: tb/tb_rw_stage.sv
// tb_rw_stage: directed, table-driven bench for rw_stage, with hand-written sequences
// for halt, asynchronous reset and counter wrap.
module tb_rw_stage;

`ifdef RW_RETIRE_CNT_EN
  localparam bit CntEn = 1'b1;
`else
  localparam bit CntEn = 1'b0;
`endif

  logic clk;
  logic reset;
  int   n_checks;
  int   n_fail;

  rw_stage_if #(.CNT_W(32)) bus ();
  rw_stage_if #(.CNT_W(4))  bus4 ();

  rw_stage #(.RA_ADR(4'hF), .CNT_W(32)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  rw_stage #(.RA_ADR(4'hF), .CNT_W(4)) dut4 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  rd;
    logic [31:0] pc;
    logic [31:0] alu;
    logic [31:0] ld;
    logic        is_ld;
    logic        is_call;
    logic        wb_in;
    logic        exp_wb;
    logic [3:0]  exp_adr;
    logic [31:0] exp_data;
  } vec_t;

  vec_t vecs[7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Drive one cycle of stimulus at the falling edge, then sample just after the rising edge.
  task automatic step(input logic valid, input logic [3:0] rd, input logic [31:0] pc,
                      input logic [31:0] alu, input logic [31:0] ld, input logic is_ld,
                      input logic is_call, input logic wb_in, input logic halt);
    @(negedge clk);
    bus.in_valid    = valid;
    bus.instruction = {6'h2A, rd, 22'h155555};
    bus.pc          = pc;
    bus.alu_result  = alu;
    bus.ld_result   = ld;
    bus.is_ld       = is_ld;
    bus.is_call     = is_call;
    bus.is_wb_in    = wb_in;
    bus.is_halt     = halt;
    @(posedge clk);
    #1;
  endtask

  task automatic check_port(input string tag, input logic wb, input logic [3:0] adr,
                            input logic [31:0] data);
    check({tag, " is_wb"},     {31'b0, bus.is_wb},     {31'b0, wb});
    check({tag, " wr_adr"},    {28'b0, bus.wr_adr},    {28'b0, adr});
    check({tag, " wr_data"},   bus.wr_data,            data);
    check({tag, " fwd_valid"}, {31'b0, bus.fwd_valid}, {31'b0, wb});
    check({tag, " fwd_adr"},   {28'b0, bus.fwd_adr},   {28'b0, adr});
    check({tag, " fwd_data"},  bus.fwd_data,           data);
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    bus.in_valid = 1'b0;
    bus.instruction = '0;
    bus.pc = '0;
    bus.alu_result = '0;
    bus.ld_result = '0;
    bus.is_ld = 1'b0;
    bus.is_call = 1'b0;
    bus.is_wb_in = 1'b0;
    bus.is_halt = 1'b0;
    bus4.in_valid = 1'b0;
    bus4.instruction = 32'h0040_0000;
    bus4.pc = '0;
    bus4.alu_result = 32'h5;
    bus4.ld_result = '0;
    bus4.is_ld = 1'b0;
    bus4.is_call = 1'b0;
    bus4.is_wb_in = 1'b1;
    bus4.is_halt = 1'b0;

    //          rd     pc            alu           ld        ld    call  wb    ewb   eadr   edata
    vecs[0] = '{4'd3, 32'h0,        32'h12,       32'h0,    1'b0, 1'b0, 1'b1, 1'b1, 4'd3,  32'h12};
    vecs[1] = '{4'd2, 32'h100,      32'h55,       32'h0,    1'b0, 1'b1, 1'b1, 1'b1, 4'hF,  32'h104};
    vecs[2] = '{4'd2, 32'hFFFFFFFC, 32'h55,       32'h0,    1'b0, 1'b1, 1'b1, 1'b1, 4'hF,  32'h0};
    vecs[3] = '{4'd6, 32'h200,      32'h99,       32'h7,    1'b1, 1'b1, 1'b1, 1'b1, 4'hF,  32'h204};
    vecs[4] = '{4'd5, 32'h300,      32'h99,       32'h7,    1'b1, 1'b0, 1'b1, 1'b1, 4'd5,  32'h7};
    vecs[5] = '{4'd0, 32'h400,      32'hAA,       32'h8,    1'b0, 1'b0, 1'b0, 1'b0, 4'd0,  32'hAA};
    vecs[6] = '{4'd9, 32'h500,      32'h1,        32'h2,    1'b0, 1'b1, 1'b0, 1'b0, 4'hF,  32'h504};

    // Reset state.
    reset = 1'b0;
    #12;
    check_port("reset", 1'b0, 4'd0, 32'h0);
    check("reset in_ready", {31'b0, bus.in_ready}, 32'd1);
    check("reset halted", {31'b0, bus.halted}, 32'd0);
    check("reset retired_cnt", bus.retired_cnt, 32'd0);
    @(negedge clk);
    reset = 1'b1;

    // Single accepts, one per vector, back to back.
    for (int i = 0; i < 7; i++) begin
      step(1'b1, vecs[i].rd, vecs[i].pc, vecs[i].alu, vecs[i].ld, vecs[i].is_ld,
           vecs[i].is_call, vecs[i].wb_in, 1'b0);
      check_port($sformatf("vec%0d", i), vecs[i].exp_wb, vecs[i].exp_adr, vecs[i].exp_data);
      check($sformatf("vec%0d in_ready", i), {31'b0, bus.in_ready}, 32'd1);
    end

    // Idle cycle: enable drops, address/data hold.
    step(1'b0, 4'd7, 32'h0, 32'hDEAD, 32'hBEEF, 1'b0, 1'b0, 1'b1, 1'b0);
    check_port("idle", 1'b0, 4'hF, 32'h504);
    check("retired after vectors", bus.retired_cnt, CntEn ? 32'd7 : 32'd0);

    // Asynchronous reset between edges while a write is pending.
    step(1'b1, 4'd4, 32'h0, 32'h77, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0);
    check_port("pre-reset", 1'b1, 4'd4, 32'h77);
    bus.in_valid = 1'b0;
    #2;
    reset = 1'b0;
    #1;
    check_port("async reset", 1'b0, 4'd0, 32'h0);
    check("async reset in_ready", {31'b0, bus.in_ready}, 32'd1);
    check("async reset retired_cnt", bus.retired_cnt, 32'd0);
    @(negedge clk);
    reset = 1'b1;

    // Halt: three accepts, the last being the halt; its write shows during the drain cycle.
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 4'(i + 1), 32'h0, 32'(16 + i), 32'h0, 1'b0, 1'b0, 1'b1, i == 2);
      check_port($sformatf("halt seq%0d", i), 1'b1, 4'(i + 1), 32'(16 + i));
      check($sformatf("halt seq%0d in_ready", i), {31'b0, bus.in_ready}, (i == 2) ? 32'd0 : 32'd1);
      check($sformatf("halt seq%0d halted", i), {31'b0, bus.halted}, 32'd0);
    end
    for (int i = 0; i < 2; i++) begin
      step(1'b1, 4'd8, 32'h0, 32'h99, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0);
      check_port($sformatf("halted%0d", i), 1'b0, 4'd3, 32'h12);
      check($sformatf("halted%0d halted", i), {31'b0, bus.halted}, 32'd1);
      check($sformatf("halted%0d in_ready", i), {31'b0, bus.in_ready}, 32'd0);
      check($sformatf("halted%0d retired_cnt", i), bus.retired_cnt, CntEn ? 32'd3 : 32'd0);
    end

    // Reset releases the halt.
    bus.in_valid = 1'b0;
    #2;
    reset = 1'b0;
    #1;
    check("halt cleared", {31'b0, bus.halted}, 32'd0);
    check("ready after halt reset", {31'b0, bus.in_ready}, 32'd1);
    @(negedge clk);
    reset = 1'b1;

    // Counter wrap on the 4-bit instance: 17 accepts.
    @(negedge clk);
    bus4.in_valid = 1'b1;
    repeat (17) @(posedge clk);
    #1;
    bus4.in_valid = 1'b0;
    check("wrap retired_cnt", {28'b0, bus4.retired_cnt}, CntEn ? 32'd1 : 32'd0);
    check("wrap is_wb", {31'b0, bus4.is_wb}, 32'd1);
    @(posedge clk);
    #1;
    check("wrap hold retired_cnt", {28'b0, bus4.retired_cnt}, CntEn ? 32'd1 : 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/rw_stage.md
# rw_stage

Register-writeback (RW) stage of the SimpleRisc pipeline. Latches one retiring instruction per cycle from the memory-access (MA) stage and drives the register bank's write port (`is_wb`, `wr_adr`, `wr_data`). It also exposes the pending write for operand forwarding and stops the pipeline cleanly when a halt instruction retires.

## Interface
Parameters:
- `RA_ADR`, 4'hF: link register written by `call`.
- `CNT_W`, 32: width of the retire counter.

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-low reset (asserted when 0).
- `in_valid`  in  1  MA presents an instruction.
- `in_ready`  out  1  stage accepts this cycle.
- `instruction`  in  32  instruction word; rd = [25:22].
- `pc`  in  32  PC of the instruction.
- `alu_result`  in  32  ALU result.
- `ld_result`  in  32  load data.
- `is_ld`  in  1  instruction is a load.
- `is_call`  in  1  instruction is `call`.
- `is_wb_in`  in  1  instruction writes a register.
- `is_halt`  in  1  instruction is the halt marker.
- `is_wb`  out  1  register-bank write enable.
- `wr_adr`  out  4  register-bank write address.
- `wr_data`  out  32  register-bank write data.
- `fwd_valid`  out  1  a write is pending this cycle (equals `is_wb`).
- `fwd_adr`  out  4  copy of `wr_adr`.
- `fwd_data`  out  32  copy of `wr_data`.
- `halted`  out  1  halt has retired; pipeline frozen.
- `retired_cnt`  out  CNT_W  count of retired instructions.

## Operation
- Accept = `in_valid && in_ready`. Inputs are sampled only on an accepting edge.
- On accept:
  - `wr_adr` <= `is_call` ? RA_ADR : `instruction[25:22]`.
  - `wr_data` <= `is_call` ? `pc+4` : (`is_ld` ? `ld_result` : `alu_result`).
  - `is_wb` <= `is_wb_in`.
- Select priority is call > load > ALU, regardless of other flags. The `pc+4` sum is modulo 2^32, so 32'hFFFFFFFC wraps to 0.
- Cycle without accept: `is_wb` <= 0. `wr_adr`/`wr_data` hold their last values.
- `in_ready` = (state == RUN). It is combinational from state only and never depends on `in_valid`.
- State machine:
  - RUN --accept with `is_halt`--> DRAIN.
  - DRAIN --next edge--> HALTED.
  - HALTED --> HALTED until reset.
- The halting instruction's own write is performed; it is visible on `is_wb` during the DRAIN cycle.
- `halted` = (state == HALTED).
- `retired_cnt` increments by 1 on every accept, including halt and non-writing instructions. It wraps at 2^CNT_W to 0.
- Write to r0 is not special: r0 is an ordinary register.

## Timing
- Latency: accept at edge N → `is_wb`/`wr_adr`/`wr_data` valid from N until N+1. The register bank commits at edge N+1.
- Throughput: one instruction per cycle in RUN; back-to-back accepts keep `is_wb` high continuously.
- `fwd_*` are combinational copies of the output registers, with no extra delay.
- Reset (`reset`=0, asynchronous, including mid-operation):
  - state = RUN, `is_wb` = 0, `wr_adr` = 0, `wr_data` = 0, `retired_cnt` = 0, `halted` = 0, `in_ready` = 1.
  - A pending write is discarded.
- Reset deassertion is synchronised externally. The first accept is possible on the first rising edge with `reset`=1.
- `in_valid` while HALTED or DRAIN is ignored; the counter does not change.

## Configuration
- `RW_RETIRE_CNT_EN` defined: retire counter implemented as above.
- Undefined: no counter flops; `retired_cnt` is tied to 0. All other behaviour is identical.

## Test plan
- Reset then ALU write: `instruction[25:22]`=3, `alu_result`=32'h12, `is_wb_in`=1, one accept → next cycle `is_wb`=1, `wr_adr`=3, `wr_data`=32'h12; the cycle after, `is_wb`=0.
- Call: `is_call`=1, `pc`=32'h100, rd field=2 → `wr_adr`=4'hF, `wr_data`=32'h104. With `pc`=32'hFFFFFFFC → `wr_data`=0.
- Priority: `is_ld`=1 and `is_call`=1, `ld_result`=7 → `wr_data`=`pc+4`. `is_ld`=1 alone → `wr_data`=7.
- Halt: three accepts, the third with `is_halt`=1 and `is_wb_in`=1 → `in_ready`=0 the next cycle with `is_wb`=1; `halted`=1 one cycle later; further `in_valid` produces no write; `retired_cnt`=3 (0 if `RW_RETIRE_CNT_EN` undefined).
- Async reset mid-stream: drive `reset`=0 between edges while `is_wb`=1 → `is_wb`, `wr_adr`, `wr_data`, `retired_cnt` go to 0 immediately with no clock edge; `in_ready`=1.
- Counter wrap (CNT_W=4): 17 accepts → `retired_cnt`=1.
